// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage and a synchronous-read imem.
interface fetch_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] imem_addr;
    logic             imem_en;
    logic [WIDTH-1:0] imem_rdata;

    modport master (output imem_addr, output imem_en, input imem_rdata);
    modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives a synchronous-read imem and presents pc/instr aligned for F/D.
module fetch_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     imem,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus4_f,
    output logic [WIDTH-1:0] instr_f,
    output logic             valid_f,
    output logic             misalign_err,
    output logic [WIDTH-1:0] fetch_count
);

    localparam logic [1:0] StReset = 2'd0;
    localparam logic [1:0] StBoot  = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q;
    logic             err_q;
    logic [WIDTH-1:0] count_q;
    logic             en;

    always_comb begin
        state_d = state_q;
        pc_d    = RESET_PC;
        en      = 1'b1;
        case (state_q)
            StReset: begin
                en      = 1'b0;
                state_d = StBoot;
            end
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                // Redirect beats stall; stall re-reads pc_q so instr_f holds steady.
                if (redirect) begin
                    pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_q + WIDTH'(4);
                end
            end
            default: begin
                en      = 1'b0;
                state_d = StReset;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReset;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_q == StBoot) || (state_q == StRun);
            if ((state_q == StRun) && redirect && (redirect_pc[1:0] != 2'b00)) begin
                err_q <= 1'b1;
            end
            if (valid_q && !stall && !redirect) begin
                count_q <= count_q + WIDTH'(1);
            end
        end
    end

    assign imem.imem_addr = pc_d;
    assign imem.imem_en   = en;

    assign pc_f         = pc_q;
    assign pc_plus4_f   = pc_q + WIDTH'(4);
    assign instr_f      = valid_q ? imem.imem_rdata : NOP_INSTR;
    assign valid_f      = valid_q;
    assign misalign_err = err_q;
    assign fetch_count  = count_q;

endmodule
